cache_refill_ctrl: RTL and testbench

Miss/writeback sequencer for the 4-way set-associative data cache. It accepts one miss at a time, writes back the dirty victim line, then fetches the missing line over a single shared line-wide memory port, and returns the line to the cache as a one-cycle fill pulse. It sits between the cache's miss/fill interface and the memory bus. It also maintains saturating miss and writeback counters and a timeout error flag.

---
 rtl/cache_refill_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// Miss/writeback sequencer for the 4-way set-associative data cache.
// Accepts one miss at a time, writes back a dirty victim, fetches the missing
// line over the shared line-wide memory port and returns it as a fill pulse.
module cache_refill_ctrl #(
   parameter int unsigned ADDRESS_WIDTH   = 32,
   parameter int unsigned LINE_SIZE_BYTES = 64,
   parameter int unsigned OFFSET_BITS     = 6,
   parameter int unsigned TIMEOUT_CYCLES  = 1024,
   parameter int unsigned CNT_WIDTH       = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           miss_valid,
   output logic                           miss_ready,
   input  logic [ADDRESS_WIDTH-1:0]       miss_addr,
   input  logic                           victim_dirty,
   input  logic [ADDRESS_WIDTH-1:0]       victim_addr,
   input  logic [LINE_SIZE_BYTES*8-1:0]   victim_data,
   output logic                           fill_valid,
   output logic [LINE_SIZE_BYTES*8-1:0]   fill_line,
   output logic                           mem_req,
   output logic                           mem_we,
   output logic [ADDRESS_WIDTH-1:0]       mem_addr,
   output logic [LINE_SIZE_BYTES*8-1:0]   mem_wdata,
   input  logic                           mem_ack,
   input  logic [LINE_SIZE_BYTES*8-1:0]   mem_rdata,
   output logic                           busy,
   output logic                           err,
   input  logic                           err_clr,
   output logic [CNT_WIDTH-1:0]           miss_count,
   output logic [CNT_WIDTH-1:0]           wb_count
);

   localparam int unsigned LINE_BITS = LINE_SIZE_BYTES * 8;
   localparam int unsigned TO_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK =
      ~((ADDRESS_WIDTH'(1) << OFFSET_BITS) - ADDRESS_WIDTH'(1));

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITEBACK,
      S_FETCH,
      S_FILL,
      S_ERROR
   } state_t;

   state_t                   r_state;
   logic [TO_W-1:0]          r_to_cnt;
   logic [ADDRESS_WIDTH-1:0] r_miss_addr;
   logic                     r_miss_ready;
   logic                     r_fill_valid;
   logic [LINE_BITS-1:0]     r_fill_line;
   logic                     r_mem_req;
   logic                     r_mem_we;
   logic [ADDRESS_WIDTH-1:0] r_mem_addr;
   logic [LINE_BITS-1:0]     r_mem_wdata;
   logic                     r_busy;
   logic                     r_err;
   logic [CNT_WIDTH-1:0]     r_miss_count;
   logic [CNT_WIDTH-1:0]     r_wb_count;

   logic [ADDRESS_WIDTH-1:0] w_miss_line;
   logic [ADDRESS_WIDTH-1:0] w_victim_line;
   logic                     w_to_hit;

   // Line-align incoming addresses and flag the last permitted wait cycle.
   assign w_miss_line   = miss_addr & ALIGN_MASK;
   assign w_victim_line = victim_addr & ALIGN_MASK;
   assign w_to_hit      = (r_to_cnt == TO_LIMIT);

   // Sequencer: state, memory request signals, fill pulse, stats and timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_to_cnt     <= '0;
         r_miss_addr  <= '0;
         r_miss_ready <= 1'b1;
         r_fill_valid <= 1'b0;
         r_fill_line  <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_busy       <= 1'b0;
         r_err        <= 1'b0;
         r_miss_count <= '0;
         r_wb_count   <= '0;
      end else begin
         r_fill_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (miss_valid) begin
                  r_miss_addr  <= w_miss_line;
                  r_miss_ready <= 1'b0;
                  r_busy       <= 1'b1;
                  r_to_cnt     <= '0;
                  r_mem_req    <= 1'b1;
                  if (r_miss_count != CNT_MAX) begin
                     r_miss_count <= r_miss_count + CNT_WIDTH'(1);
                  end
                  if (victim_dirty) begin
                     r_state     <= S_WRITEBACK;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= w_victim_line;
                     r_mem_wdata <= victim_data;
                  end else begin
                     r_state     <= S_FETCH;
                     r_mem_we    <= 1'b0;
                     r_mem_addr  <= w_miss_line;
                     r_mem_wdata <= '0;
                  end
               end
            end

            S_WRITEBACK: begin
               if (mem_ack) begin
                  // Request stays high; only direction/address/data switch.
                  r_state     <= S_FETCH;
                  r_to_cnt    <= '0;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= r_miss_addr;
                  r_mem_wdata <= '0;
                  if (r_wb_count != CNT_MAX) begin
                     r_wb_count <= r_wb_count + CNT_WIDTH'(1);
                  end
               end else if (w_to_hit) begin
                  r_state     <= S_ERROR;
                  r_err       <= 1'b1;
                  r_to_cnt    <= '0;
                  r_mem_req   <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_wdata <= '0;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end

            S_FETCH: begin
               if (mem_ack) begin
                  r_state      <= S_FILL;
                  r_fill_line  <= mem_rdata;
                  r_fill_valid <= 1'b1;
                  r_to_cnt     <= '0;
                  r_mem_req    <= 1'b0;
                  r_mem_addr   <= '0;
               end else if (w_to_hit) begin
                  r_state     <= S_ERROR;
                  r_err       <= 1'b1;
                  r_to_cnt    <= '0;
                  r_mem_req   <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_wdata <= '0;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end

            S_FILL: begin
               r_state      <= S_IDLE;
               r_miss_ready <= 1'b1;
               r_busy       <= 1'b0;
            end

            S_ERROR: begin
               if (err_clr) begin
                  r_state      <= S_IDLE;
                  r_err        <= 1'b0;
                  r_miss_ready <= 1'b1;
                  r_busy       <= 1'b0;
               end
            end

            default: begin
               r_state      <= S_IDLE;
               r_miss_ready <= 1'b1;
               r_busy       <= 1'b0;
               r_mem_req    <= 1'b0;
            end
         endcase
      end
   end

   // Outputs come straight from registers.
   assign miss_ready = r_miss_ready;
   assign fill_valid = r_fill_valid;
   assign fill_line  = r_fill_line;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign busy       = r_busy;
   assign err        = r_err;
   assign miss_count = r_miss_count;
   assign wb_count   = r_wb_count;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed, table-driven bench for cache_refill_ctrl (TIMEOUT_CYCLES=8, CNT_WIDTH=2).
module tb_cache_refill_ctrl;

   localparam int unsigned AW = 32;
   localparam int unsigned LB = 512;

   localparam logic [LB-1:0] PA = {16{32'hA5A5_0001}};
   localparam logic [LB-1:0] PB = {16{32'h5A5A_0002}};
   localparam logic [LB-1:0] PC = {16{32'h0F0F_0003}};
   localparam logic [LB-1:0] PD = {16{32'hC3C3_0004}};
   localparam logic [LB-1:0] PE = {16{32'h1234_0005}};
   localparam logic [LB-1:0] PF = {16{32'h9999_0006}};
   localparam logic [LB-1:0] PG = {16{32'h7777_0007}};

   logic          clk, rst;
   logic          miss_valid, miss_ready;
   logic [AW-1:0] miss_addr;
   logic          victim_dirty;
   logic [AW-1:0] victim_addr;
   logic [LB-1:0] victim_data;
   logic          fill_valid;
   logic [LB-1:0] fill_line;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [LB-1:0] mem_wdata;
   logic          mem_ack;
   logic [LB-1:0] mem_rdata;
   logic          busy, err, err_clr;
   logic [1:0]    miss_count, wb_count;

   int total = 0;
   int bad   = 0;

   cache_refill_ctrl #(
      .ADDRESS_WIDTH  (32),
      .LINE_SIZE_BYTES(64),
      .OFFSET_BITS    (6),
      .TIMEOUT_CYCLES (8),
      .CNT_WIDTH      (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .miss_valid  (miss_valid),
      .miss_ready  (miss_ready),
      .miss_addr   (miss_addr),
      .victim_dirty(victim_dirty),
      .victim_addr (victim_addr),
      .victim_data (victim_data),
      .fill_valid  (fill_valid),
      .fill_line   (fill_line),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .busy        (busy),
      .err         (err),
      .err_clr     (err_clr),
      .miss_count  (miss_count),
      .wb_count    (wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] maddr;
      logic          dirty;
      logic [AW-1:0] vaddr;
      logic [LB-1:0] vdata;
      int            wbw;
      int            few;
      logic [LB-1:0] rdata;
      logic [AW-1:0] exp_va;
      logic [AW-1:0] exp_ma;
      logic [1:0]    exp_mc;
      logic [1:0]    exp_wc;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      miss_valid   = 1'b0;
      miss_addr    = '0;
      victim_dirty = 1'b0;
      victim_addr  = '0;
      victim_data  = '0;
      mem_ack      = 1'b0;
      mem_rdata    = '0;
      err_clr      = 1'b0;
   endtask

   // Reset with miss_valid asserted to show reset wins; ends at a negedge in IDLE.
   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst        = 1'b1;
      miss_valid = 1'b1;
      miss_addr  = 32'h0000_4000;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_miss_ready", miss_ready, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_miss_count", miss_count, 0);
      chk("rst_wb_count", wb_count, 0);
      chk("rst_err", err, 0);
      chk("rst_fill_valid", fill_valid, 0);
      chk("rst_fill_line", fill_line, 0);
      chk("rst_mem_addr", mem_addr, 0);
      miss_valid = 1'b0;
      rst        = 1'b0;
      @(negedge clk);
   endtask

   // One complete miss transaction from a table record; starts and ends at a negedge in IDLE.
   task automatic run_vec(input vec_t v);
      chk("pre_miss_ready", miss_ready, 1);
      miss_valid   = 1'b1;
      miss_addr    = v.maddr;
      victim_dirty = v.dirty;
      victim_addr  = v.vaddr;
      victim_data  = v.vdata;
      @(negedge clk);
      miss_valid   = 1'b0;
      miss_addr    = '0;
      victim_addr  = '0;
      victim_data  = '0;
      victim_dirty = 1'b0;
      chk("acc_busy", busy, 1);
      chk("acc_miss_ready", miss_ready, 0);
      if (v.dirty) begin
         for (int k = 0; k <= v.wbw; k++) begin
            chk("wb_req", mem_req, 1);
            chk("wb_we", mem_we, 1);
            chk("wb_addr", mem_addr, v.exp_va);
            chk("wb_wdata", mem_wdata, v.vdata);
            chk("wb_err", err, 0);
            if (k == v.wbw) mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
         end
      end
      for (int k = 0; k <= v.few; k++) begin
         chk("fe_req", mem_req, 1);
         chk("fe_we", mem_we, 0);
         chk("fe_addr", mem_addr, v.exp_ma);
         chk("fe_wdata", mem_wdata, 0);
         chk("fe_fill_valid", fill_valid, 0);
         if (k == v.few) begin
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
         end
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = '0;
      end
      chk("fill_valid", fill_valid, 1);
      chk("fill_line", fill_line, v.rdata);
      chk("fill_mem_req", mem_req, 0);
      chk("fill_busy", busy, 1);
      @(negedge clk);
      chk("post_fill_valid", fill_valid, 0);
      chk("post_fill_line", fill_line, v.rdata);
      chk("post_miss_ready", miss_ready, 1);
      chk("post_busy", busy, 0);
      chk("post_err", err, 0);
      chk("post_miss_count", miss_count, v.exp_mc);
      chk("post_wb_count", wb_count, v.exp_wc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      idle_inputs();

      // maddr, dirty, vaddr, vdata, wb wait, fetch wait, rdata, exp victim line, exp miss line, exp counts
      tbl[0] = '{32'h0000_1234, 1'b0, 32'h0000_0000, PA, 0, 0, PA, 32'h0000_0000, 32'h0000_1200, 2'd1, 2'd0};
      tbl[1] = '{32'h0000_9A00, 1'b1, 32'h0000_5640, PB, 3, 3, PC, 32'h0000_5640, 32'h0000_9A00, 2'd2, 2'd1};
      tbl[2] = '{32'hFFFF_FFFF, 1'b0, 32'h0000_0000, PA, 0, 7, PD, 32'h0000_0000, 32'hFFFF_FFC0, 2'd3, 2'd1};
      tbl[3] = '{32'hDEAD_BEEF, 1'b1, 32'h1234_567F, PE, 7, 7, PF, 32'h1234_5640, 32'hDEAD_BEC0, 2'd3, 2'd2};
      tbl[4] = '{32'h0000_0040, 1'b0, 32'h0000_0000, PA, 0, 0, PG, 32'h0000_0000, 32'h0000_0040, 2'd3, 2'd2};
      tbl[5] = '{32'h0001_0010, 1'b1, 32'h0002_0020, PC, 0, 0, PA, 32'h0002_0000, 32'h0001_0000, 2'd3, 2'd3};
      tbl[6] = '{32'h0003_003F, 1'b1, 32'h0004_0041, PD, 1, 2, PB, 32'h0004_0040, 32'h0003_0000, 2'd3, 2'd3};

      do_reset();
      for (int i = 0; i < 7; i++) run_vec(tbl[i]);

      // Timeout: 8 unacked request cycles, then ERROR ignores misses until err_clr.
      do_reset();
      miss_valid = 1'b1;
      miss_addr  = 32'h0000_3010;
      @(negedge clk);
      miss_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("to_req_held", mem_req, 1);
         chk("to_no_err_yet", err, 0);
         @(negedge clk);
      end
      chk("to_req_dropped", mem_req, 0);
      chk("to_err", err, 1);
      chk("to_miss_ready", miss_ready, 0);
      chk("to_busy", busy, 1);
      miss_valid = 1'b1;
      mem_ack    = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("err_hold_err", err, 1);
         chk("err_hold_busy", busy, 1);
         chk("err_hold_req", mem_req, 0);
         chk("err_ignored_miss", miss_count, 1);
      end
      miss_valid = 1'b0;
      mem_ack    = 1'b0;
      err_clr    = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("clr_err", err, 0);
      chk("clr_miss_ready", miss_ready, 1);
      chk("clr_busy", busy, 0);

      // Reset in the middle of FETCH abandons the transaction immediately.
      do_reset();
      miss_valid = 1'b1;
      miss_addr  = 32'h0000_7080;
      @(negedge clk);
      miss_valid = 1'b0;
      chk("mid_req", mem_req, 1);
      @(negedge clk);
      chk("mid_req2", mem_req, 1);
      chk("mid_count", miss_count, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_req", mem_req, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_fill", fill_valid, 0);
      chk("mid_rst_count", miss_count, 0);
      mem_ack   = 1'b1;
      mem_rdata = PA;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("mid_no_fill", fill_valid, 0);
         chk("mid_idle_busy", busy, 0);
         chk("mid_fill_line", fill_line, 0);
      end
      mem_ack   = 1'b0;
      mem_rdata = '0;
      chk("mid_counts_wb", wb_count, 0);

      // Back-to-back misses with miss_valid and mem_ack held high.
      do_reset();
      begin
         logic [4:0] fv_seen;
         logic [4:0] busy_seen;
         logic [4:0] fv_exp;
         logic [4:0] busy_exp;
         fv_exp   = 5'b10010;
         busy_exp = 5'b11011;
         miss_valid = 1'b1;
         miss_addr  = 32'h0000_2000;
         mem_ack    = 1'b1;
         mem_rdata  = PC;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            fv_seen[k]   = fill_valid;
            busy_seen[k] = busy;
         end
         miss_valid = 1'b0;
         mem_ack    = 1'b0;
         chk("b2b_fill_pattern", fv_seen, fv_exp);
         chk("b2b_busy_pattern", busy_seen, busy_exp);
         @(negedge clk);
         chk("b2b_miss_count", miss_count, 2);
         chk("b2b_fill_line", fill_line, PC);
         chk("b2b_idle", busy, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
